// File: rtl/pmem_arbiter_pkg.sv
// pmem_arbiter_pkg: shared types for the physical-memory line-port arbiter.
package pmem_arbiter_pkg;
   localparam int PMEM_ADDR_W = 32;
   localparam int PMEM_LINE_W = 256;
   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} arb_state_t;
   typedef enum logic {REQ_I, REQ_D} arb_req_t;
   typedef struct packed {
      logic                   read;
      logic                   write;
      logic [PMEM_ADDR_W-1:0] address;
      logic [PMEM_LINE_W-1:0] wdata;
   } pmem_cmd_t;
endpackage

// File: rtl/pmem_arb_grant.sv
// pmem_arb_grant: picks the I- or D-cache winner from the pending bits.
// PMEM_ARB_DCACHE_PRIORITY_EN makes D win every tie instead of alternating.
module pmem_arb_grant
   import pmem_arbiter_pkg::*;
(
   input  logic     pend_i,
   input  logic     pend_d,
   input  arb_req_t last_grant,
   output logic     gnt_valid,
   output arb_req_t gnt
);
   arb_req_t tie;
`ifdef PMEM_ARB_DCACHE_PRIORITY_EN
   assign tie = REQ_D;
`else
   assign tie = (last_grant == REQ_D) ? REQ_I : REQ_D;
`endif
   assign gnt_valid = pend_i | pend_d;
   assign gnt = (pend_i & pend_d) ? tie : (pend_i ? REQ_I : REQ_D);
endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: grants the shared line port to one cache at a time and routes the response back.
// Tie-break policy selectable with PMEM_ARB_DCACHE_PRIORITY_EN (default round-robin).
module pmem_arbiter
   import pmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = PMEM_ADDR_W,
   parameter int LINE_W = PMEM_LINE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_pmem_read,
   input  logic [ADDR_W-1:0] i_pmem_address,
   output logic [LINE_W-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [ADDR_W-1:0] d_pmem_address,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   output logic [LINE_W-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic              arb_pmem_read,
   output logic              arb_pmem_write,
   output logic [ADDR_W-1:0] arb_pmem_address,
   output logic [LINE_W-1:0] arb_pmem_wdata,
   input  logic [LINE_W-1:0] arb_pmem_rdata,
   input  logic              arb_pmem_resp,
   output logic              arb_busy
);
   arb_state_t state_q, state_d;
   arb_req_t   last_q, last_d, gnt;
   pmem_cmd_t  cmd_q, cmd_d;
   logic       gnt_valid;

   pmem_arb_grant u_grant (
      .pend_i     (i_pmem_read),
      .pend_d     (d_pmem_read | d_pmem_write),
      .last_grant (last_q),
      .gnt_valid  (gnt_valid),
      .gnt        (gnt)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cmd_d   = cmd_q;
      case (state_q)
         IDLE: if (gnt_valid) begin
            state_d       = (gnt == REQ_I) ? I_BUSY : D_BUSY;
            cmd_d.write   = (gnt == REQ_D) & d_pmem_write;
            cmd_d.read    = ~cmd_d.write;
            cmd_d.address = (gnt == REQ_I) ? i_pmem_address : d_pmem_address;
            cmd_d.wdata   = cmd_d.write ? d_pmem_wdata : '0;
         end
         I_BUSY, D_BUSY: if (arb_pmem_resp) begin
            state_d = DONE;
            last_d  = (state_q == I_BUSY) ? REQ_I : REQ_D;
            cmd_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= REQ_D;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cmd_q   <= cmd_d;
      end
   end

   // Command register is cleared on response, so the port idles at zero outside a transaction.
   assign arb_pmem_read    = cmd_q.read;
   assign arb_pmem_write   = cmd_q.write;
   assign arb_pmem_address = cmd_q.address;
   assign arb_pmem_wdata   = cmd_q.wdata;
   assign arb_busy         = state_q != IDLE;
   assign i_pmem_resp      = arb_pmem_resp & (state_q == I_BUSY);
   assign d_pmem_resp      = arb_pmem_resp & (state_q == D_BUSY);
   assign i_pmem_rdata     = i_pmem_resp ? arb_pmem_rdata : '0;
   assign d_pmem_rdata     = d_pmem_resp ? arb_pmem_rdata : '0;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed bench with a transaction-level model checked every cycle.
// Honours PMEM_ARB_DCACHE_PRIORITY_EN for the expected tie winner.
module tb_pmem_arbiter;
   logic         clk = 0;
   logic         rst;
   logic         i_pmem_read, d_pmem_read, d_pmem_write, arb_pmem_resp;
   logic [31:0]  i_pmem_address, d_pmem_address;
   logic [255:0] d_pmem_wdata, arb_pmem_rdata;
   logic [255:0] i_pmem_rdata, d_pmem_rdata, arb_pmem_wdata;
   logic         i_pmem_resp, d_pmem_resp, arb_pmem_read, arb_pmem_write, arb_busy;
   logic [31:0]  arb_pmem_address;

   int n_chk = 0;
   int n_fail = 0;

   pmem_arbiter dut (
      .clk(clk), .rst(rst),
      .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
      .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
      .arb_pmem_read(arb_pmem_read), .arb_pmem_write(arb_pmem_write),
      .arb_pmem_address(arb_pmem_address), .arb_pmem_wdata(arb_pmem_wdata),
      .arb_pmem_rdata(arb_pmem_rdata), .arb_pmem_resp(arb_pmem_resp),
      .arb_busy(arb_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: owner 0 = nobody, 1 = I-cache, 2 = D-cache.
   int           own, last;
   bit           gap;
   logic         m_rd, m_wr;
   logic [31:0]  m_ad;
   logic [255:0] m_wd;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         own = 0; gap = 0; last = 2;
         m_rd = 0; m_wr = 0; m_ad = 0; m_wd = 0;
      end else if (own != 0) begin
         if (arb_pmem_resp) begin
            last = own; own = 0; gap = 1;
         end
      end else if (gap) begin
         gap = 0;
      end else begin
         if (i_pmem_read && (d_pmem_read || d_pmem_write))
`ifdef PMEM_ARB_DCACHE_PRIORITY_EN
            own = 2;
`else
            own = (last == 1) ? 2 : 1;
`endif
         else if (i_pmem_read) own = 1;
         else if (d_pmem_read || d_pmem_write) own = 2;
         if (own == 1) begin
            m_rd = 1; m_wr = 0; m_ad = i_pmem_address; m_wd = 0;
         end else if (own == 2) begin
            m_wr = d_pmem_write; m_rd = !d_pmem_write; m_ad = d_pmem_address;
            m_wd = d_pmem_write ? d_pmem_wdata : 256'd0;
         end
      end
   end

   always @(negedge clk) begin
      #2;
      chk("cmp_read",  arb_pmem_read,    own != 0 && m_rd);
      chk("cmp_write", arb_pmem_write,   own != 0 && m_wr);
      chk("cmp_addr",  arb_pmem_address, own != 0 ? m_ad : 32'd0);
      chk("cmp_wdata", arb_pmem_wdata,   own != 0 ? m_wd : 256'd0);
      chk("cmp_busy",  arb_busy,         own != 0 || gap);
      chk("cmp_iresp", i_pmem_resp,      own == 1 && arb_pmem_resp);
      chk("cmp_dresp", d_pmem_resp,      own == 2 && arb_pmem_resp);
      chk("cmp_irdat", i_pmem_rdata,     (own == 1 && arb_pmem_resp) ? arb_pmem_rdata : 256'd0);
      chk("cmp_drdat", d_pmem_rdata,     (own == 2 && arb_pmem_resp) ? arb_pmem_rdata : 256'd0);
   end

   localparam logic [255:0] RD_A5 = {32{8'hA5}};
   localparam logic [255:0] WD_12 = {8{32'h12345678}};
   logic [31:0] exp_addr [4];

   initial begin
      rst = 0; i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; arb_pmem_resp = 0;
      i_pmem_address = 0; d_pmem_address = 0; d_pmem_wdata = 0; arb_pmem_rdata = 0;
`ifdef PMEM_ARB_DCACHE_PRIORITY_EN
      exp_addr = '{32'h200, 32'h200, 32'h200, 32'h200};
`else
      exp_addr = '{32'h100, 32'h200, 32'h100, 32'h200};
`endif
      repeat (3) @(negedge clk);
      #3 chk("reset_busy", arb_busy, 0);
      chk("reset_read", arb_pmem_read, 0);
      @(negedge clk) rst = 1;
      // single I-cache read
      @(negedge clk); i_pmem_read = 1; i_pmem_address = 32'h1000;
      #3 chk("t1_no_cmd_at_grant", arb_pmem_read, 0);
      @(negedge clk); #3 chk("t1_read", arb_pmem_read, 1);
      chk("t1_addr", arb_pmem_address, 32'h1000);
      @(negedge clk); arb_pmem_resp = 1; arb_pmem_rdata = RD_A5;
      #3 chk("t1_iresp", i_pmem_resp, 1);
      chk("t1_irdata", i_pmem_rdata, RD_A5);
      chk("t1_dresp", d_pmem_resp, 0);
      @(negedge clk); arb_pmem_resp = 0; arb_pmem_rdata = 0; i_pmem_read = 0;
      #3 chk("t1_done_busy", arb_busy, 1);
      chk("t1_read_drop", arb_pmem_read, 0);
      @(negedge clk); #3 chk("t1_idle_busy", arb_busy, 0);
      // D-cache writeback with 10-cycle adaptor latency
      @(negedge clk); d_pmem_write = 1; d_pmem_address = 32'h2040; d_pmem_wdata = WD_12;
      @(negedge clk); #3 chk("t2_write", arb_pmem_write, 1);
      chk("t2_addr", arb_pmem_address, 32'h2040);
      repeat (10) begin
         @(negedge clk); #3 chk("t2_wdata_hold", arb_pmem_wdata, WD_12);
         chk("t2_dresp_quiet", d_pmem_resp, 0);
      end
      @(negedge clk); arb_pmem_resp = 1;
      #3 chk("t2_dresp", d_pmem_resp, 1);
      chk("t2_iresp", i_pmem_resp, 0);
      @(negedge clk); arb_pmem_resp = 0; d_pmem_write = 0; d_pmem_wdata = 0;
      #3 chk("t2_dresp_pulse", d_pmem_resp, 0);
      chk("t2_write_drop", arb_pmem_write, 0);
      @(negedge clk);
      // simultaneous requests from reset, both re-requesting after each service
      rst = 0;
      @(negedge clk); rst = 1;
      @(negedge clk); i_pmem_read = 1; i_pmem_address = 32'h100; d_pmem_read = 1; d_pmem_address = 32'h200;
      @(negedge clk); #3;
      for (int k = 0; k < 4; k++) begin
         chk("rr_winner", arb_pmem_address, exp_addr[k]);
         @(negedge clk); arb_pmem_resp = 1; arb_pmem_rdata = {32{k[7:0]}};
         #3 chk("rr_resp", exp_addr[k] == 32'h100 ? i_pmem_resp : d_pmem_resp, 1);
         @(negedge clk); arb_pmem_resp = 0;
         if (exp_addr[k] == 32'h100) i_pmem_read = 0; else d_pmem_read = 0;
         @(negedge clk); i_pmem_read = 1; d_pmem_read = 1;
         #3 chk("rr_idle", arb_busy, 0);
         @(negedge clk); #3;
      end
      @(negedge clk); arb_pmem_resp = 1;
      @(negedge clk); arb_pmem_resp = 0; i_pmem_read = 0; d_pmem_read = 0;
      @(negedge clk);
      // I-cache holds its request through DONE
      @(negedge clk); i_pmem_read = 1; i_pmem_address = 32'h4000;
      @(negedge clk); #3 chk("t4_read", arb_pmem_read, 1);
      @(negedge clk); arb_pmem_resp = 1;
      #3 chk("t4_iresp", i_pmem_resp, 1);
      @(negedge clk); arb_pmem_resp = 0;
      #3 chk("t4_done_busy", arb_busy, 1);
      @(negedge clk); i_pmem_read = 0;
      #3 chk("t4_no_regrant", arb_busy, 0);
      @(negedge clk); #3 chk("t4_idle_read", arb_pmem_read, 0);
      chk("t4_idle_busy", arb_busy, 0);
      // asynchronous reset during a D transaction, then a stray response
      @(negedge clk); d_pmem_read = 1; d_pmem_address = 32'h3000;
      @(negedge clk); chk("t5_pre_read", arb_pmem_read, 1);
      #1 rst = 0; d_pmem_read = 0; arb_pmem_resp = 1;
      #1 chk("t5_read_async", arb_pmem_read, 0);
      chk("t5_addr_async", arb_pmem_address, 0);
      chk("t5_busy_async", arb_busy, 0);
      chk("t5_dresp_async", d_pmem_resp, 0);
      @(negedge clk); rst = 1;
      #3 chk("t5_stray_dresp", d_pmem_resp, 0);
      chk("t5_stray_iresp", i_pmem_resp, 0);
      @(negedge clk); arb_pmem_resp = 0;
      #3 chk("t5_busy", arb_busy, 0);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
